// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the RX/TX controllers.
package uart_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int OVERSAMPLING       = 16;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_t;

    // FIFO entry carries the word plus its parity-error flag.
    function automatic int fifo_entry_width(input int word_width);
        return word_width + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with flush; push data visible at head 1 cycle after push into empty.
// Backpressure: push dropped when full unless a pop happens the same cycle; pop on empty ignored.
module uart_sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: parity check, receive FIFO, sticky errors, idle timeout, registered irq.
// Latency 1 from des_ready to rd_valid; full FIFO drops frames (overrun) unless popped same cycle.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int TIMEOUT_TICKS = 640,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  cfg_rx_en,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    input  logic [LW-1:0]         cfg_thresh,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  des_parity_en,
    input  logic                  des_ready,
    input  logic [WORD_WIDTH:0]   des_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_perr,
    output logic [LW-1:0]         level,
    output logic                  err_overrun,
    output logic                  err_parity,
    output logic                  timeout,
    output logic                  irq
);

    localparam int            EW    = fifo_entry_width(WORD_WIDTH);
    localparam int            TW    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_TICKS);

    par_mode_t             par_mode;
    logic [WORD_WIDTH-1:0] word;
    logic                  pbit;
    logic                  perr;
    logic                  push_req;
    logic                  pop_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         head;
    logic [TW-1:0]         idle_cnt;
    logic                  thresh_hit;

    assign des_parity_en = cfg_parity_en;

    always_comb begin
        par_mode = cfg_parity_odd ? PAR_ODD : PAR_EVEN;
        word     = des_data[WORD_WIDTH:1];
        pbit     = 1'b0;
        perr     = 1'b0;
        if (cfg_parity_en) begin
            word = des_data[WORD_WIDTH-1:0];
            pbit = des_data[WORD_WIDTH];
            perr = (^word ^ pbit) != (par_mode == PAR_ODD);
        end
    end

    assign push_req = des_ready & cfg_rx_en;
    assign pop_req  = rd_ready & rd_valid;

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat ({perr, word}),
        .pop      (rd_ready),
        .flush    (flush),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign rd_valid           = ~fifo_empty;
    assign {rd_perr, rd_data} = head;

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun <= 1'b0;
            err_parity  <= 1'b0;
        end else begin
            err_overrun <= (push_req & fifo_full & ~rd_ready & ~flush) | (err_overrun & ~clr_err);
            err_parity  <= (push_req & perr) | (err_parity & ~clr_err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (flush | push_req | pop_req | fifo_empty) begin
            idle_cnt <= '0;
        end else if (tick && idle_cnt != T_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout    = (idle_cnt == T_MAX);
    assign thresh_hit = (cfg_thresh != '0) && (level >= cfg_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= thresh_hit | timeout | err_overrun | err_parity;
        end
    end

endmodule
